udt_ctrl_regs: RTL and testbench

//  AXI4-Lite responder holding the UDT core control/status register file; the far end of the

---
 rtl/udt_ctrl_pkg.sv | 21 ++
 rtl/axil_wr_capture.sv | 53 +++++
 rtl/udt_ctrl_regs.sv | 135 +++++++++++++
 tb/tb_udt_ctrl_regs.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/udt_ctrl_pkg.sv
// udt_ctrl_pkg: register map, AXI response codes, connection states and FSM encodings for udt_ctrl_regs
package udt_ctrl_pkg;
  localparam logic [2:0] REG_MSS     = 3'd0;
  localparam logic [2:0] REG_WINDOW  = 3'd1;
  localparam logic [2:0] REG_SND_BUF = 3'd2;
  localparam logic [2:0] REG_RCV_BUF = 3'd3;
  localparam logic [2:0] REG_TIMEOUT = 3'd4;
  localparam logic [2:0] REG_CONNECT = 3'd5;
  localparam logic [2:0] REG_CLOSE   = 3'd6;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [31:0] CONN_ST_CONNECTED = 32'h10;
  localparam logic [31:0] CONN_ST_CLOSED    = 32'h1000;
  typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = s[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/axil_wr_capture.sv
// axil_wr_capture: independent one-deep AW and W capture buffers; ready is high while a buffer is empty
module axil_wr_capture #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  input  logic                clr_i,
  output logic                have_aw_o,
  output logic                have_w_o,
  output logic [ADDR_W-1:0]   addr_o,
  output logic [DATA_W-1:0]   data_o,
  output logic [DATA_W/8-1:0] strb_o
);
  logic                aw_full_q, w_full_q;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [DATA_W/8-1:0] w_strb_q;
  logic                aw_hs, w_hs;
  assign awready_o = !aw_full_q;
  assign wready_o  = !w_full_q;
  assign aw_hs     = awvalid_i & !aw_full_q;
  assign w_hs      = wvalid_i & !w_full_q;
  // Live channel values bypass the buffer so a same-cycle handshake completes immediately
  assign have_aw_o = aw_full_q | awvalid_i;
  assign have_w_o  = w_full_q | wvalid_i;
  assign addr_o    = aw_full_q ? aw_addr_q : awaddr_i;
  assign data_o    = w_full_q ? w_data_q : wdata_i;
  assign strb_o    = w_full_q ? w_strb_q : wstrb_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= clr_i ? 1'b0 : aw_full_q | aw_hs;
      w_full_q  <= clr_i ? 1'b0 : w_full_q | w_hs;
      if (aw_hs) aw_addr_q <= awaddr_i;
      if (w_hs) begin
        w_data_q <= wdata_i;
        w_strb_q <= wstrb_i;
      end
    end
endmodule

// File: rtl/udt_ctrl_regs.sv
// udt_ctrl_regs: AXI4-Lite control/status register file for the UDT core.
// UDT_CTRL_REGS_RREADY_IGNORE_EN: rvalid becomes a one-cycle pulse that ignores rready.
module udt_ctrl_regs
  import udt_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MSS_RST = 1500,
  parameter int WIN_RST = 8192
) (
  input  logic                core_clk,
  input  logic                core_rst,
  input  logic [ADDR_W-1:0]   ctrl_s_axi_awaddr,
  input  logic                ctrl_s_axi_awvalid,
  output logic                ctrl_s_axi_awready,
  input  logic [DATA_W-1:0]   ctrl_s_axi_wdata,
  input  logic [DATA_W/8-1:0] ctrl_s_axi_wstrb,
  input  logic                ctrl_s_axi_wvalid,
  output logic                ctrl_s_axi_wready,
  output logic [1:0]          ctrl_s_axi_bresp,
  output logic                ctrl_s_axi_bvalid,
  input  logic                ctrl_s_axi_bready,
  input  logic [ADDR_W-1:0]   ctrl_s_axi_araddr,
  input  logic                ctrl_s_axi_arvalid,
  output logic                ctrl_s_axi_arready,
  output logic [DATA_W-1:0]   ctrl_s_axi_rdata,
  output logic [1:0]          ctrl_s_axi_rresp,
  output logic                ctrl_s_axi_rvalid,
  input  logic                ctrl_s_axi_rready,
  output logic [DATA_W-1:0]   cfg_mss,
  output logic [DATA_W-1:0]   cfg_window,
  output logic [DATA_W-1:0]   cfg_snd_buf,
  output logic [DATA_W-1:0]   cfg_rcv_buf,
  output logic [DATA_W-1:0]   cfg_timeout,
  input  logic                cfg_lock,
  input  logic [DATA_W-1:0]   conn_state,
  output logic                connect_req,
  output logic                close_req
);
  localparam logic [DATA_W-1:0] RST_VAL [5] = '{DATA_W'(MSS_RST), DATA_W'(WIN_RST), DATA_W'(8192), DATA_W'(8192), DATA_W'(1000)};
  wr_state_e           wr_st_q, wr_st_d;
  rd_state_e           rd_st_q, rd_st_d;
  logic [DATA_W-1:0]   cfg_q [5];
  logic [1:0]          bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                connect_q, close_q;
  logic                have_aw, have_w, fire, b_done, ar_hs, r_done;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic [2:0]          w_idx, r_idx;
  logic                w_ok, w_cfg, w_conn, w_close, r_ok, r_cfg, r_st;
  logic [1:0]          w_resp, rd_resp;
  logic [DATA_W-1:0]   rd_val;
  axil_wr_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cap (
    .clk_i     (core_clk),
    .rst_i     (core_rst),
    .awaddr_i  (ctrl_s_axi_awaddr),
    .awvalid_i (ctrl_s_axi_awvalid),
    .awready_o (ctrl_s_axi_awready),
    .wdata_i   (ctrl_s_axi_wdata),
    .wstrb_i   (ctrl_s_axi_wstrb),
    .wvalid_i  (ctrl_s_axi_wvalid),
    .wready_o  (ctrl_s_axi_wready),
    .clr_i     (b_done),
    .have_aw_o (have_aw),
    .have_w_o  (have_w),
    .addr_o    (w_addr),
    .data_o    (w_data),
    .strb_o    (w_strb)
  );
  assign fire    = (wr_st_q != W_RESP) & have_aw & have_w;
  assign b_done  = (wr_st_q == W_RESP) & ctrl_s_axi_bready;
  assign w_idx   = w_addr[2:0];
  assign w_ok    = w_addr[ADDR_W-1:3] == '0;
  assign w_cfg   = w_ok && w_idx <= REG_TIMEOUT;
  assign w_conn  = w_ok && w_idx == REG_CONNECT;
  assign w_close = w_ok && w_idx == REG_CLOSE;
  assign w_resp  = ((w_cfg && !cfg_lock) || w_conn || w_close) ? RESP_OKAY : RESP_SLVERR;
  always_comb begin
    wr_st_d = wr_st_q;
    wr_st_d = b_done ? W_IDLE : fire ? W_RESP : (wr_st_q == W_IDLE && (have_aw || have_w)) ? W_HALF : wr_st_q;
  end
  assign ar_hs   = (rd_st_q == R_IDLE) & ctrl_s_axi_arvalid;
`ifdef UDT_CTRL_REGS_RREADY_IGNORE_EN
  assign r_done  = (rd_st_q == R_DATA) & (1'b1 | ctrl_s_axi_rready);
`else
  assign r_done  = (rd_st_q == R_DATA) & ctrl_s_axi_rready;
`endif
  assign r_idx   = ctrl_s_axi_araddr[2:0];
  assign r_ok    = ctrl_s_axi_araddr[ADDR_W-1:3] == '0;
  assign r_cfg   = r_ok && r_idx <= REG_TIMEOUT;
  assign r_st    = r_ok && (r_idx == REG_CONNECT || r_idx == REG_CLOSE);
  assign rd_val  = r_cfg ? cfg_q[r_idx] : r_st ? conn_state : '0;
  assign rd_resp = (r_cfg || r_st) ? RESP_OKAY : RESP_SLVERR;
  always_comb begin
    rd_st_d = rd_st_q;
    rd_st_d = ar_hs ? R_DATA : r_done ? R_IDLE : rd_st_q;
  end
  always_ff @(posedge core_clk or posedge core_rst)
    if (core_rst) begin
      wr_st_q   <= W_IDLE;
      rd_st_q   <= R_IDLE;
      for (int i = 0; i < 5; i++) cfg_q[i] <= RST_VAL[i];
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      connect_q <= 1'b0;
      close_q   <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      connect_q <= fire & w_conn;
      close_q   <= fire & w_close;
      if (fire) bresp_q <= w_resp;
      if (fire && w_cfg && !cfg_lock) cfg_q[w_idx] <= strb_merge(cfg_q[w_idx], w_data, w_strb);
      if (ar_hs) begin
        rdata_q <= rd_val;
        rresp_q <= rd_resp;
      end
    end
  assign ctrl_s_axi_bvalid  = wr_st_q == W_RESP;
  assign ctrl_s_axi_bresp   = bresp_q;
  assign ctrl_s_axi_arready = rd_st_q == R_IDLE;
  assign ctrl_s_axi_rvalid  = rd_st_q == R_DATA;
  assign ctrl_s_axi_rdata   = rdata_q;
  assign ctrl_s_axi_rresp   = rresp_q;
  assign cfg_mss            = cfg_q[REG_MSS];
  assign cfg_window         = cfg_q[REG_WINDOW];
  assign cfg_snd_buf        = cfg_q[REG_SND_BUF];
  assign cfg_rcv_buf        = cfg_q[REG_RCV_BUF];
  assign cfg_timeout        = cfg_q[REG_TIMEOUT];
  assign connect_req        = connect_q;
  assign close_req          = close_q;
endmodule

// File: tb/tb_udt_ctrl_regs.sv
// tb_udt_ctrl_regs: directed table-driven bench for udt_ctrl_regs plus multi-cycle corner sequences
module tb_udt_ctrl_regs;
  import udt_ctrl_pkg::*;
  logic        core_clk = 1'b0, core_rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, conn_state = '0;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0, cfg_lock = 1'b0;
  logic [31:0] cfg_mss, cfg_window, cfg_snd_buf, cfg_rcv_buf, cfg_timeout;
  logic        connect_req, close_req;
  int          errors = 0, checks = 0, conn_cnt = 0, close_cnt = 0;

  udt_ctrl_regs dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .ctrl_s_axi_awaddr(awaddr), .ctrl_s_axi_awvalid(awvalid), .ctrl_s_axi_awready(awready),
    .ctrl_s_axi_wdata(wdata), .ctrl_s_axi_wstrb(wstrb), .ctrl_s_axi_wvalid(wvalid), .ctrl_s_axi_wready(wready),
    .ctrl_s_axi_bresp(bresp), .ctrl_s_axi_bvalid(bvalid), .ctrl_s_axi_bready(bready),
    .ctrl_s_axi_araddr(araddr), .ctrl_s_axi_arvalid(arvalid), .ctrl_s_axi_arready(arready),
    .ctrl_s_axi_rdata(rdata), .ctrl_s_axi_rresp(rresp), .ctrl_s_axi_rvalid(rvalid), .ctrl_s_axi_rready(rready),
    .cfg_mss(cfg_mss), .cfg_window(cfg_window), .cfg_snd_buf(cfg_snd_buf), .cfg_rcv_buf(cfg_rcv_buf),
    .cfg_timeout(cfg_timeout), .cfg_lock(cfg_lock), .conn_state(conn_state),
    .connect_req(connect_req), .close_req(close_req)
  );

  always #5 core_clk = ~core_clk;

  always @(negedge core_clk) begin
    if (connect_req) conn_cnt++;
    if (close_req) close_cnt++;
    if (connect_req && close_req) begin
      errors++;
      $display("FAIL req_exclusive: connect_req and close_req both 1, required at most one");
    end
  end

  typedef struct {
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        lk;
    logic [31:0] cs;
    logic [1:0]  eb;
    logic [31:0] er;
    logic [1:0]  err;
    int          ec, ecl;
  } vec_t;
  vec_t v [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] cfg_sel(input logic [31:0] a);
    return a == 0 ? cfg_mss : a == 1 ? cfg_window : a == 2 ? cfg_snd_buf : a == 3 ? cfg_rcv_buf : cfg_timeout;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    output logic b1, output logic b2, output logic [1:0] br);
    @(negedge core_clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    b1 = bvalid; br = bresp;
    @(negedge core_clk);
    b2 = bvalid;
    bready = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic r1, output logic [31:0] d, output logic [1:0] rr);
    @(negedge core_clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    @(negedge core_clk);
    arvalid = 1'b0;
    r1 = rvalid; d = rdata; rr = rresp;
    @(negedge core_clk);
    rready = 1'b0;
  endtask

  initial begin
    logic        b1, b2, r1;
    logic [1:0]  br, rr;
    logic [31:0] rdv, held;
    int          c0, l0;
    v[0]  = '{32'd0, 32'd1024, 4'hF, 1'b0, 32'd0, RESP_OKAY, 32'd1024, RESP_OKAY, 0, 0};
    v[1]  = '{32'd1, 32'd4096, 4'hF, 1'b0, 32'd0, RESP_OKAY, 32'd4096, RESP_OKAY, 0, 0};
    v[2]  = '{32'd2, 32'd4096, 4'hF, 1'b0, 32'd0, RESP_OKAY, 32'd4096, RESP_OKAY, 0, 0};
    v[3]  = '{32'd3, 32'd10240, 4'hF, 1'b0, 32'd0, RESP_OKAY, 32'd10240, RESP_OKAY, 0, 0};
    v[4]  = '{32'd4, 32'd8192, 4'hF, 1'b0, 32'd0, RESP_OKAY, 32'd8192, RESP_OKAY, 0, 0};
    v[5]  = '{32'd5, 32'hFFFF, 4'hF, 1'b0, CONN_ST_CONNECTED, RESP_OKAY, 32'h10, RESP_OKAY, 1, 0};
    v[6]  = '{32'd6, 32'd0, 4'hF, 1'b0, CONN_ST_CLOSED, RESP_OKAY, 32'h1000, RESP_OKAY, 0, 1};
    v[7]  = '{32'd0, 32'd9000, 4'hF, 1'b1, 32'd0, RESP_SLVERR, 32'd1024, RESP_OKAY, 0, 0};
    v[8]  = '{32'd7, 32'd5, 4'hF, 1'b0, 32'd0, RESP_SLVERR, 32'd0, RESP_SLVERR, 0, 0};
    v[9]  = '{32'd1, 32'hAABBCCDD, 4'b0010, 1'b0, 32'd0, RESP_OKAY, 32'h0000CC00, RESP_OKAY, 0, 0};
    v[10] = '{32'h108, 32'd1, 4'hF, 1'b0, 32'd0, RESP_SLVERR, 32'd0, RESP_SLVERR, 0, 0};
    repeat (2) @(negedge core_clk);
    core_rst = 1'b0;
    @(negedge core_clk);
    chk("rst_awready", awready, 1); chk("rst_wready", wready, 1); chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0); chk("rst_rvalid", rvalid, 0); chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0); chk("rst_rdata", rdata, 0);
    chk("rst_mss", cfg_mss, 1500); chk("rst_window", cfg_window, 8192); chk("rst_snd", cfg_snd_buf, 8192);
    chk("rst_rcv", cfg_rcv_buf, 8192); chk("rst_timeout", cfg_timeout, 1000);
    chk("rst_reqs", {connect_req, close_req}, 0);

    for (int i = 0; i < 11; i++) begin
      cfg_lock = v[i].lk; conn_state = v[i].cs; c0 = conn_cnt; l0 = close_cnt;
      wr(v[i].a, v[i].d, v[i].s, b1, b2, br);
      chk($sformatf("v%0d_bvalid", i), b1, 1);
      chk($sformatf("v%0d_bdone", i), b2, 0);
      chk($sformatf("v%0d_bresp", i), br, v[i].eb);
      chk($sformatf("v%0d_connect", i), conn_cnt - c0, v[i].ec);
      chk($sformatf("v%0d_close", i), close_cnt - l0, v[i].ecl);
      if (v[i].a < 5) chk($sformatf("v%0d_cfg", i), cfg_sel(v[i].a), v[i].er);
      rd(v[i].a, r1, rdv, rr);
      chk($sformatf("v%0d_rvalid", i), r1, 1);
      chk($sformatf("v%0d_rdata", i), rdv, v[i].er);
      chk($sformatf("v%0d_rresp", i), rr, v[i].err);
      cfg_lock = 1'b0;
    end

    // W three cycles ahead of AW, one-cycle valids, late bready
    @(negedge core_clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge core_clk);
    wvalid = 1'b0;
    chk("split_wready_low", wready, 0); chk("split_awready_high", awready, 1); chk("split_bvalid_early", bvalid, 0);
    repeat (2) @(negedge core_clk);
    awaddr = 32'd2; awvalid = 1'b1;
    @(negedge core_clk);
    awvalid = 1'b0;
    chk("split_bvalid", bvalid, 1); chk("split_cfg", cfg_snd_buf, 32'h12345678); chk("split_awready_low", awready, 0);
    repeat (3) @(negedge core_clk);
    chk("split_bvalid_held", bvalid, 1); chk("split_bresp", bresp, RESP_OKAY);
    bready = 1'b1;
    @(negedge core_clk);
    bready = 1'b0;
    chk("split_bdone", bvalid, 0); chk("split_ready_again", {awready, wready}, 2'b11);
    repeat (2) @(negedge core_clk);
    chk("split_single", bvalid, 0);

    // reset with a write response and a read response both pending
    @(negedge core_clk);
    awaddr = 32'd3; wdata = 32'h55; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    araddr = 32'd0; arvalid = 1'b1; rready = 1'b0;
    @(negedge core_clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("pend_bvalid", bvalid, 1); chk("pend_rvalid", rvalid, 1); chk("pend_rcv", cfg_rcv_buf, 32'h55);
    #2 core_rst = 1'b1;
    #1;
    chk("arst_bvalid", bvalid, 0); chk("arst_rvalid", rvalid, 0); chk("arst_rdata", rdata, 0);
    chk("arst_readies", {awready, wready, arready}, 3'b111); chk("arst_rcv", cfg_rcv_buf, 8192);
    chk("arst_mss", cfg_mss, 1500);
    @(negedge core_clk);
    core_rst = 1'b0;
    @(negedge core_clk);
    araddr = 32'd1; arvalid = 1'b1; rready = 1'b0;
    @(negedge core_clk);
    arvalid = 1'b0;
    chk("rr_rvalid", rvalid, 1); chk("rr_rdata", rdata, 8192);
    held = rdata;
`ifdef UDT_CTRL_REGS_RREADY_IGNORE_EN
    @(negedge core_clk);
    chk("rr_pulse", rvalid, 0); chk("rr_arready", arready, 1);
`else
    chk("rr_arready_low", arready, 0);
    repeat (3) @(negedge core_clk);
    chk("rr_held", rvalid, 1); chk("rr_stable", rdata, held);
    rready = 1'b1;
    @(negedge core_clk);
    rready = 1'b0;
    chk("rr_done", rvalid, 0); chk("rr_arready", arready, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
